ov7670_window_capture: RTL and testbench

Parametrised frame grabber for the OV7670 pixel bus. It sits between the sensor pins and the framebuffer write port and generalises single-byte capture. It adds:
- 1- or 2-byte pixel packing (e.g. RGB565);
- a programmable crop window into a sensor frame of any size;
- single-shot or continuous frame acquisition, with a per-frame done pulse;
- line-length error detection.

Framebuffer addresses are linear and window-relative, starting at 0 on every frame.

---
 rtl/ov7670_window_capture.sv | 140 ++++++++++++++
 tb/tb_ov7670_window_capture.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_window_capture.sv
// OV7670 frame grabber: crops a WIN_W x WIN_H window, packs BPP bytes per pixel, writes addr 0.. per frame.
// Latency: we one cycle after a pixel's last byte; no backpressure, the framebuffer must take every write.
module ov7670_window_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter int WIN_W    = 176,
    parameter int WIN_H    = 132,
    parameter int BPP      = 2,
    parameter int ADDR_W   = 16
) (
    input  logic                pclk_24,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    input  logic                vsync,
    input  logic                href,
    input  logic [7:0]          d,
    output logic                we,
    output logic [ADDR_W-1:0]   addr,
    output logic [8*BPP-1:0]    dout,
    output logic                busy,
    output logic                frame_done,
    output logic                err_line
);

    localparam int PIX_W = 8 * BPP;
    localparam int XW    = $clog2(H_ACTIVE + 2);
    localparam int YW    = $clog2(V_ACTIVE + 2);
    localparam int TOTAL = WIN_W * WIN_H;
    localparam logic [XW-1:0] X_SAT   = XW'(H_ACTIVE + 1);
    localparam logic [YW-1:0] Y_SAT   = YW'(V_ACTIVE + 1);
    localparam logic          PH_LAST = 1'(BPP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE
    } state_t;

    state_t            state;
    logic              vsync_d;
    logic              href_d;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              phase;
    logic [ADDR_W:0]   wcnt;
    logic [PIX_W-1:0]  acc;
    logic [PIX_W-1:0]  pix;
    logic              in_win;
    logic              vs_fall;
    logic              vs_rise;
    logic              hr_fall;

    // Earlier bytes of the pixel sit in the low bytes of acc; the newest byte lands last.
    assign pix     = PIX_W'({acc, d});
    assign vs_fall = vsync_d && !vsync;
    assign vs_rise = vsync && !vsync_d;
    assign hr_fall = href_d && !href;
    assign in_win  = (int'(x) >= X0) && (int'(x) < X0 + WIN_W) &&
                     (int'(y) >= Y0) && (int'(y) < Y0 + WIN_H) &&
                     (int'(wcnt) < TOTAL);

    always_ff @(posedge pclk_24) begin
        if (reset) begin
            state      <= S_IDLE;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            wcnt       <= '0;
            acc        <= '0;
            we         <= 1'b0;
            addr       <= '0;
            dout       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_line   <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            href_d     <= href;
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ARMED;
                        busy     <= 1'b1;
                        err_line <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (vs_fall) begin
                        state <= S_CAPTURE;
                        x     <= '0;
                        y     <= '0;
                        phase <= 1'b0;
                        wcnt  <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (vs_rise) begin
                        // A line still open at frame end is abandoned and flagged.
                        frame_done <= 1'b1;
                        if (y != YW'(V_ACTIVE) || href)
                            err_line <= 1'b1;
                        state <= continuous ? S_ARMED : S_IDLE;
                        busy  <= continuous;
                    end else if (href) begin
                        acc <= pix;
                        if (phase == PH_LAST) begin
                            phase <= 1'b0;
                            if (x != X_SAT)
                                x <= x + 1'b1;
                            if (in_win) begin
                                we   <= 1'b1;
                                addr <= wcnt[ADDR_W-1:0];
                                dout <= pix;
                                wcnt <= wcnt + 1'b1;
                            end
                        end else begin
                            phase <= 1'b1;
                        end
                    end else if (hr_fall) begin
                        if (x != XW'(H_ACTIVE) || phase != 1'b0)
                            err_line <= 1'b1;
                        if (y != Y_SAT)
                            y <= y + 1'b1;
                        x     <= '0;
                        phase <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_window_capture.sv
// Directed + randomized bench for ov7670_window_capture: a 2-byte and a 1-byte build share the sensor bus.
module tb_ov7670_window_capture;

    localparam int HA = 8, VA = 6, WX0 = 2, WY0 = 1, WW = 4, WH = 3;

    logic        pclk_24 = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0, start2 = 1'b0;
    logic        continuous = 1'b0;
    logic        vsync = 1'b1;
    logic        href = 1'b0;
    logic [7:0]  d = 8'h00;

    logic        we2, busy2, fd2, err2;
    logic [3:0]  addr2;
    logic [15:0] dout2;
    logic        we1, busy1, fd1, err1;
    logic [3:0]  addr1;
    logic [7:0]  dout1;

    int ncmp = 0;
    int nfail = 0;
    int sel = 2;

    logic [7:0]  fdat [8][16];
    int          lens [8];
    logic [15:0] exp_a[$], exp_d[$];
    logic        exp_err;
    logic [15:0] ga2[$], gd2[$], ga1[$], gd1[$];
    int          nfd2 = 0, nfd1 = 0;

    always #5 pclk_24 = ~pclk_24;

    ov7670_window_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .X0(WX0), .Y0(WY0),
                            .WIN_W(WW), .WIN_H(WH), .BPP(2), .ADDR_W(4)) dut2 (
        .pclk_24(pclk_24), .reset(reset), .start(start2), .continuous(continuous),
        .vsync(vsync), .href(href), .d(d), .we(we2), .addr(addr2), .dout(dout2),
        .busy(busy2), .frame_done(fd2), .err_line(err2));

    ov7670_window_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .X0(WX0), .Y0(WY0),
                            .WIN_W(WW), .WIN_H(WH), .BPP(1), .ADDR_W(4)) dut1 (
        .pclk_24(pclk_24), .reset(reset), .start(start1), .continuous(continuous),
        .vsync(vsync), .href(href), .d(d), .we(we1), .addr(addr1), .dout(dout1),
        .busy(busy1), .frame_done(fd1), .err_line(err1));

    always @(negedge pclk_24) begin
        if (we2) begin ga2.push_back({12'h000, addr2}); gd2.push_back(dout2); end
        if (we1) begin ga1.push_back({12'h000, addr1}); gd1.push_back({8'h00, dout1}); end
        if (fd2) nfd2++;
        if (fd1) nfd1++;
    end

    task automatic tick();
        @(negedge pclk_24);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        if (sel == 2) start2 = 1'b1; else start1 = 1'b1;
        tick();
        start2 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic fill(input int bpp, input bit rnd);
        for (int l = 0; l < 8; l++) begin
            lens[l] = 8 * bpp;
            for (int k = 0; k < 16; k++)
                fdat[l][k] = rnd ? 8'($urandom) : 8'(l * 16 + k);
        end
    endtask

    task automatic clear_got();
        ga2.delete(); gd2.delete(); ga1.delete(); gd1.delete();
        exp_a.delete(); exp_d.delete();
        nfd2 = 0; nfd1 = 0;
        exp_err = 1'b0;
    endtask

    // Reference: walk the frame as pixels, keep those inside the window, number them in order.
    task automatic build_expect(input int bpp, input int nlines);
        int cnt = 0;
        if (nlines != VA) exp_err = 1'b1;
        for (int y = 0; y < nlines; y++) begin
            int npix = lens[y] / bpp;
            if (lens[y] != HA * bpp) exp_err = 1'b1;
            if (y >= WY0 && y < WY0 + WH)
                for (int x = WX0; x < WX0 + WW && x < npix; x++)
                    if (cnt < WW * WH) begin
                        exp_a.push_back(16'(cnt));
                        exp_d.push_back(bpp == 2 ? {fdat[y][2*x], fdat[y][2*x+1]}
                                                 : {8'h00, fdat[y][x]});
                        cnt++;
                    end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        if (sel == 2) begin
            chk({tag, " we"}, 32'(we2), 0);     chk({tag, " addr"}, 32'(addr2), 0);
            chk({tag, " dout"}, 32'(dout2), 0); chk({tag, " busy"}, 32'(busy2), 0);
            chk({tag, " fd"}, 32'(fd2), 0);     chk({tag, " err"}, 32'(err2), 0);
        end else begin
            chk({tag, " we1"}, 32'(we1), 0);    chk({tag, " busy1"}, 32'(busy1), 0);
            chk({tag, " dout1"}, 32'(dout1), 0);chk({tag, " err1"}, 32'(err1), 0);
        end
    endtask

    // One sensor frame: blanking, vsync fall, lines separated by random gaps, vsync rise.
    task automatic drive_frame(input int nlines, input int start_line, input int drop_line,
                               input int rst_after);
        bit rst_done = 1'b0;
        vsync = 1'b1; href = 1'b0;
        repeat (3) tick();
        vsync = 1'b0;
        if (start_line == -2) pulse_start(); else tick();
        repeat ($urandom_range(1, 3)) tick();
        for (int l = 0; l < nlines; l++) begin
            if (l == start_line) pulse_start();
            if (l == drop_line) continuous = 1'b0;
            href = 1'b1;
            for (int k = 0; k < lens[l]; k++) begin
                d = fdat[l][k];
                tick();
                if (rst_after > 0 && !rst_done && ga2.size() == rst_after) begin
                    rst_done = 1'b1;
                    reset = 1'b1;
                    tick();
                    check_outputs_zero("rst_mid");
                    reset = 1'b0;
                end
            end
            href = 1'b0;
            d = 8'h00;
            repeat ($urandom_range(2, 4)) tick();
        end
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag, input int exp_fd, input logic exp_busy);
        logic [15:0] ga[$], gd[$];
        int fd;
        logic b, e;
        if (sel == 2) begin ga = ga2; gd = gd2; fd = nfd2; b = busy2; e = err2; end
        else          begin ga = ga1; gd = gd1; fd = nfd1; b = busy1; e = err1; end
        chk({tag, " nwrites"}, 32'(ga.size()), 32'(exp_a.size()));
        for (int i = 0; i < ga.size() && i < exp_a.size(); i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 32'(ga[i]), 32'(exp_a[i]));
            chk($sformatf("%s dout[%0d]", tag, i), 32'(gd[i]), 32'(exp_d[i]));
        end
        chk({tag, " frame_done"}, 32'(fd), 32'(exp_fd));
        chk({tag, " busy"}, 32'(b), 32'(exp_busy));
        chk({tag, " err_line"}, 32'(e), 32'(exp_err));
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        sel = 2; check_outputs_zero("reset");
        sel = 1; check_outputs_zero("reset");

        // Single clean frame, linear data
        sel = 2; clear_got(); fill(2, 1'b0);
        pulse_start();
        chk("busy_rise", 32'(busy2), 1);
        drive_frame(VA, -1, -1, 0);
        build_expect(2, VA);
        check_frame("single", 1, 1'b0);
        if (gd2.size() == 12) begin
            chk("first_dout", 32'(gd2[0]), 32'h1415);
            chk("last_dout", 32'(gd2[11]), 32'h3A3B);
            chk("last_addr", 32'(ga2[11]), 11);
        end else chk("single_count", 32'(gd2.size()), 12);

        // Continuous: three random frames, then drop continuous mid-frame
        clear_got(); continuous = 1'b1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            fill(2, 1'b1);
            drive_frame(VA, -1, -1, 0);
            build_expect(2, VA);
        end
        check_frame("cont3", 3, 1'b1);
        clear_got(); fill(2, 1'b1);
        drive_frame(VA, -1, 2, 0);
        build_expect(2, VA);
        check_frame("cont_drop", 1, 1'b0);
        clear_got(); fill(2, 1'b1);
        drive_frame(VA, -1, -1, 0);
        check_frame("after_drop", 0, 1'b0);

        // Short line on row 2 with random length
        clear_got(); fill(2, 1'b1);
        lens[2] = $urandom_range(1, 15);
        pulse_start();
        drive_frame(VA, -1, -1, 0);
        build_expect(2, VA);
        check_frame("short_line", 1, 1'b0);

        // Arm mid-frame: that frame is skipped; a second start while busy is ignored
        clear_got(); fill(2, 1'b1);
        drive_frame(VA, 2, -1, 0);
        chk("armed_busy", 32'(busy2), 1);
        chk("armed_nowrite", 32'(ga2.size()), 0);
        fill(2, 1'b1);
        drive_frame(VA, 3, -1, 0);
        build_expect(2, VA);
        check_frame("mid_arm", 1, 1'b0);

        // Start coincident with the vsync fall: capture begins one frame later
        clear_got(); fill(2, 1'b1);
        drive_frame(VA, -2, -1, 0);
        chk("coinc_nowrite", 32'(ga2.size()), 0);
        fill(2, 1'b1);
        drive_frame(VA, -1, -1, 0);
        build_expect(2, VA);
        check_frame("coinc_start", 1, 1'b0);

        // Reset after the 5th write, then a normal frame
        clear_got(); fill(2, 1'b1);
        pulse_start();
        drive_frame(VA, -1, -1, 5);
        build_expect(2, VA);
        exp_a = exp_a[0:4]; exp_d = exp_d[0:4];
        check_frame("reset_mid", 0, 1'b0);
        clear_got(); fill(2, 1'b1);
        pulse_start();
        drive_frame(VA, -1, -1, 0);
        build_expect(2, VA);
        check_frame("post_reset", 1, 1'b0);

        // 1-byte build
        sel = 1; clear_got(); fill(1, 1'b0);
        pulse_start();
        drive_frame(VA, -1, -1, 0);
        build_expect(1, VA);
        check_frame("bpp1", 1, 1'b0);
        if (gd1.size() > 0) chk("bpp1_first", 32'(gd1[0]), 32'h12);
        else chk("bpp1_count", 32'(gd1.size()), 12);
        chk("bpp1_other_idle", 32'(ga2.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
